// File: rtl/emu_clk_osc.sv
`default_nettype none
// ============================================================================
// Module      : emu_clk_osc
// Description : Emulated-time clock oscillator. Produces a clock whose low and
//               high phases last t_lo / t_hi units of emulated time. Each
//               emulator cycle it requests the time left in the current phase
//               (dt_req) from the timestep arbiter. It consumes the granted
//               emu_dt and toggles when the phase budget reaches zero.
// Ports       : clk_i       emulator clock (rising edge)
//               rst_n_i     synchronous active-low reset
//               en_i        oscillator enable
//               t_lo, t_hi  low / high phase durations (DT_SCALE units)
//               emu_dt      granted timestep for this cycle
//               dt_req      requested timestep (remaining phase time)
//               clk_o       emulated clock
//               rise_o      one-cycle pulse on the 0->1 edge of clk_o
//               fall_o      one-cycle pulse on the 1->0 edge of clk_o
//               emu_time_o  accumulated emulated time
//               err_o       sticky error: a grant exceeded the request
// Revision    : 1.0 - initial release
// ============================================================================
module emu_clk_osc #(
  parameter int unsigned         DT_WIDTH   = 32,
  parameter int unsigned         TIME_WIDTH = 64,
  parameter logic [DT_WIDTH-1:0] DT_MAX     = {DT_WIDTH{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DT_WIDTH-1:0]   t_lo,
  input  logic [DT_WIDTH-1:0]   t_hi,
  input  logic [DT_WIDTH-1:0]   emu_dt,
  output logic [DT_WIDTH-1:0]   dt_req,
  output logic                  clk_o,
  output logic                  rise_o,
  output logic                  fall_o,
  output logic [TIME_WIDTH-1:0] emu_time_o,
  output logic                  err_o
);

  localparam logic [DT_WIDTH-1:0] C_ONE = DT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [DT_WIDTH-1:0] remaining, remaining_nx;
  logic                clk_nx, rise_nx, fall_nx, err_nx;
  logic [DT_WIDTH-1:0] eff_lo, eff_hi;

  // Zero durations become one unit so a running oscillator never stalls.
  assign eff_lo = (t_lo == '0) ? C_ONE : t_lo;
  assign eff_hi = (t_hi == '0) ? C_ONE : t_hi;

  assign dt_req = ((state == LO) || (state == HI)) ? remaining : DT_MAX;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    clk_nx       = clk_o;
    rise_nx      = 1'b0;
    fall_nx      = 1'b0;
    err_nx       = err_o;
    case (state)
      IDLE: begin
        clk_nx = 1'b0;
        if (en_i) begin
          state_nx     = LO;
          remaining_nx = eff_lo;
        end
      end
      LO: begin
        // remaining is never zero here, so a zero grant simply holds it.
        if (emu_dt < remaining) begin
          remaining_nx = remaining - emu_dt;
        end else begin
          if (emu_dt > remaining) err_nx = 1'b1;
          if (en_i) begin
            state_nx     = HI;
            clk_nx       = 1'b1;
            rise_nx      = 1'b1;
            remaining_nx = eff_hi;
          end else begin
            // Disabled: the pending rise is dropped and we park low.
            state_nx     = IDLE;
            clk_nx       = 1'b0;
            remaining_nx = '0;
          end
        end
      end
      HI: begin
        if (emu_dt < remaining) begin
          remaining_nx = remaining - emu_dt;
        end else begin
          if (emu_dt > remaining) err_nx = 1'b1;
          clk_nx  = 1'b0;
          fall_nx = 1'b1;
          if (en_i) begin
            state_nx     = LO;
            remaining_nx = eff_lo;
          end else begin
            state_nx     = IDLE;
            remaining_nx = '0;
          end
        end
      end
      default: begin
        state_nx     = IDLE;
        clk_nx       = 1'b0;
        remaining_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      remaining  <= '0;
      clk_o      <= 1'b0;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
      err_o      <= 1'b0;
      emu_time_o <= '0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      clk_o      <= clk_nx;
      rise_o     <= rise_nx;
      fall_o     <= fall_nx;
      err_o      <= err_nx;
      // Emulated time advances in every state and wraps naturally.
      emu_time_o <= emu_time_o + TIME_WIDTH'(emu_dt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_emu_clk_osc.sv
`default_nettype none
// ============================================================================
// Module      : tb_emu_clk_osc
// Description : Self-checking bench for emu_clk_osc. A deadline-based model
//               (absolute emulated time at which the current phase ends)
//               predicts every output each cycle; directed sequences add
//               hand-computed literal expectations.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emu_clk_osc;

  localparam logic [31:0] DT_MAX = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] t_lo = 32'd123;
  logic [31:0] t_hi = 32'd234;
  logic [31:0] emu_dt = 32'd0;
  logic [31:0] dt_req;
  logic        clk_o, rise_o, fall_o, err_o;
  logic [63:0] emu_time;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  emu_clk_osc dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .t_lo       (t_lo),
    .t_hi       (t_hi),
    .emu_dt     (emu_dt),
    .dt_req     (dt_req),
    .clk_o      (clk_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .emu_time_o (emu_time),
    .err_o      (err_o)
  );

  // Model: running flag, clock level, and the absolute emulated time at
  // which the current phase ends.
  bit          m_run = 1'b0, m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_err = 1'b0;
  logic [63:0] m_time = 64'd0, m_end = 64'd0;

  function automatic logic [31:0] eff(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  function automatic logic [31:0] m_req();
    logic [63:0] d;
    d = m_end - m_time;
    return m_run ? d[31:0] : DT_MAX;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [63:0] left, nt;
    if (!rst_n) begin
      m_run = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_err = 0;
      m_time = 64'd0; m_end = 64'd0;
    end else begin
      m_rise = 0; m_fall = 0;
      left = m_end - m_time;
      nt   = m_time + {32'd0, emu_dt};
      if (!m_run) begin
        if (en) begin
          m_run = 1;
          m_end = nt + {32'd0, eff(t_lo)};
        end
      end else if ({32'd0, emu_dt} >= left) begin
        if ({32'd0, emu_dt} > left) m_err = 1;
        if (!m_lvl) begin
          if (en) begin
            m_lvl = 1; m_rise = 1;
            m_end = nt + {32'd0, eff(t_hi)};
          end else begin
            m_run = 0;
          end
        end else begin
          m_lvl = 0; m_fall = 1;
          if (en) m_end = nt + {32'd0, eff(t_lo)};
          else    m_run = 0;
        end
      end
      m_time = nt;
    end
  end

  always @(negedge clk) begin
    check("cmp_clk",    {63'd0, clk_o},  {63'd0, m_lvl});
    check("cmp_rise",   {63'd0, rise_o}, {63'd0, m_rise});
    check("cmp_fall",   {63'd0, fall_o}, {63'd0, m_fall});
    check("cmp_err",    {63'd0, err_o},  {63'd0, m_err});
    check("cmp_time",   emu_time, m_time);
    check("cmp_dt_req", {32'd0, dt_req}, {32'd0, m_req()});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_nominal(input int n);
    for (int k = 0; k < n; k++) begin
      emu_dt = m_req();
      tick();
    end
  endtask

  int unsigned fexp [6] = '{100, 70, 40, 10, 50, 20};
  logic [63:0] last;
  logic [31:0] step;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_clk",    {63'd0, clk_o}, 64'd0);
    check("rst_dt_req", {32'd0, dt_req}, {32'd0, DT_MAX});
    check("rst_time",   emu_time, 64'd0);
    check("rst_err",    {63'd0, err_o}, 64'd0);

    // Nominal clock: grant exactly what is requested
    rst_n = 1; en = 1;
    emu_dt = m_req(); tick();
    check("nom_start_time", emu_time, 64'hFFFF_FFFF);
    last = emu_time;
    for (int i = 0; i < 20; i++) begin
      emu_dt = m_req(); tick();
      check("nom_edge", {61'd0, clk_o, rise_o, fall_o}, (i % 2 == 0) ? 64'd6 : 64'd1);
      check("nom_span", emu_time - last, (i % 2 == 0) ? 64'd123 : 64'd234);
      last = emu_time;
    end
    check("nom_total", emu_time, 64'd4294970865);
    check("nom_err",   {63'd0, err_o}, 64'd0);

    // Foreign smaller timestep caps each grant at 30
    rst_n = 0; tick();
    rst_n = 1; t_lo = 100; t_hi = 50; emu_dt = 30; tick();
    for (int i = 0; i < 6; i++) begin
      check("fgn_dt_req", {32'd0, dt_req}, {32'd0, fexp[i]});
      step = m_req();
      emu_dt = (step < 32'd30) ? step : 32'd30;
      tick();
      check("fgn_rise", {63'd0, rise_o}, (i == 3) ? 64'd1 : 64'd0);
      check("fgn_fall", {63'd0, fall_o}, (i == 5) ? 64'd1 : 64'd0);
    end

    // Zero durations clamp to one unit
    rst_n = 0; tick();
    rst_n = 1; t_lo = 0; t_hi = 0; emu_dt = 0; tick();
    for (int i = 0; i < 6; i++) begin
      check("zero_dt_req", {32'd0, dt_req}, 64'd1);
      emu_dt = 1; tick();
      check("zero_clk", {63'd0, clk_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Mid-phase update of t_hi while low: next high phase uses new value
    rst_n = 0; tick();
    rst_n = 1; t_lo = 123; t_hi = 234; emu_dt = 0; tick();
    emu_dt = 23; tick();
    t_hi = 500;
    emu_dt = 100; tick();
    check("midlo_rise",  {63'd0, rise_o}, 64'd1);
    check("midlo_len",   {32'd0, dt_req}, 64'd500);
    emu_dt = 500; t_hi = 234; tick();
    check("midlo_fall",  {63'd0, fall_o}, 64'd1);
    emu_dt = 123; tick();
    check("midhi_len",   {32'd0, dt_req}, 64'd234);
    // Update while high: current phase keeps 234, the next one uses 500
    t_hi = 500;
    emu_dt = 34; tick();
    check("midhi_keep",  {32'd0, dt_req}, 64'd200);
    emu_dt = 200; tick();
    check("midhi_fall",  {63'd0, fall_o}, 64'd1);
    emu_dt = 123; tick();
    check("midhi_next",  {32'd0, dt_req}, 64'd500);

    // Protocol violation: overshoot the remaining 500 by 5
    emu_dt = 505; tick();
    check("viol_err",    {63'd0, err_o},  64'd1);
    check("viol_fall",   {63'd0, fall_o}, 64'd1);
    run_nominal(4);
    check("viol_sticky", {63'd0, err_o},  64'd1);
    rst_n = 0; tick();
    check("viol_clear",  {63'd0, err_o},  64'd0);

    // Disable while high: finish the phase with a fall, then park
    rst_n = 1; t_lo = 123; t_hi = 234; en = 1; emu_dt = 0; tick();
    emu_dt = 123; tick();
    emu_dt = 34; tick();
    en = 0; emu_dt = 200; tick();
    check("dis_fall",    {63'd0, fall_o}, 64'd1);
    check("dis_clk",     {63'd0, clk_o},  64'd0);
    check("dis_dt_req",  {32'd0, dt_req}, {32'd0, DT_MAX});
    emu_dt = 7; tick();
    check("dis_idle",    {32'd0, dt_req}, {32'd0, DT_MAX});

    // Disable while low: the pending rise is dropped
    en = 1; emu_dt = 0; tick();
    en = 0; emu_dt = 123; tick();
    check("dislo_rise",  {63'd0, rise_o}, 64'd0);
    check("dislo_dt",    {32'd0, dt_req}, {32'd0, DT_MAX});

    // Reset mid-low
    en = 1; emu_dt = 0; tick();
    emu_dt = 50; tick();
    check("rstlo_pre",   {32'd0, dt_req}, 64'd73);
    rst_n = 0; tick();
    check("rstlo_clk",   {63'd0, clk_o},  64'd0);
    check("rstlo_rise",  {63'd0, rise_o}, 64'd0);
    check("rstlo_fall",  {63'd0, fall_o}, 64'd0);
    check("rstlo_time",  emu_time, 64'd0);
    check("rstlo_dt",    {32'd0, dt_req}, {32'd0, DT_MAX});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/emu_clk_osc.md
Name: emu_clk_osc

Overview:
- Emulated-time clock oscillator: the generator side of the t_lo/t_hi interface driven by the simulation controller.
- Produces an emulated clock whose low and high durations, measured in emulated time, equal t_lo and t_hi in DT_SCALE units.
- Each emulator cycle it requests a timestep (dt_req) from the global timestep arbiter. It consumes the granted emu_dt, and toggles exactly when its phase budget is exhausted.
- Sits beside analog models under the emulator time manager.

Parameters:
- DT_WIDTH, 32, width of t_lo/t_hi/dt_req/emu_dt (DT_SCALE units).
- TIME_WIDTH, 64, width of the emulated-time accumulator.
- DT_MAX, 2**DT_WIDTH-1, dt_req value when the block imposes no constraint.

Ports:
- clk_i  in  1  emulator clock; all logic on its rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- en_i  in  1  oscillator enable.
- t_lo  in  DT_WIDTH  low-phase duration.
- t_hi  in  DT_WIDTH  high-phase duration.
- emu_dt  in  DT_WIDTH  timestep granted this cycle (min over all requesters).
- dt_req  out  DT_WIDTH  requested timestep = remaining phase time.
- clk_o  out  1  emulated clock value.
- rise_o  out  1  one-cycle pulse, same cycle clk_o goes 0->1.
- fall_o  out  1  one-cycle pulse, same cycle clk_o goes 1->0.
- emu_time_o  out  TIME_WIDTH  accumulated emulated time (sum of emu_dt).
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - state=IDLE, clk_o=0, rise_o=0, fall_o=0, err_o=0, emu_time_o=0.
  - remaining=0; dt_req=DT_MAX.
  - Reset mid-phase discards the partial phase.
- States:
  - IDLE: clk_o=0, dt_req=DT_MAX.
    - en_i=1 -> LO, remaining <= eff(t_lo).
  - LO and HI: dt_req=remaining, combinationally from the register.
- eff(x) = (x==0) ? 1 : x. Zero durations are clamped to 1 so the oscillator always advances.
- Every non-reset cycle: emu_time_o <= emu_time_o + emu_dt. The sum wraps modulo 2**TIME_WIDTH, and it accumulates in every state, including IDLE.
- In LO/HI, each cycle:
  - emu_dt < remaining: remaining <= remaining - emu_dt; no edge.
  - emu_dt == remaining:
    - LO -> HI: clk_o<=1, rise_o<=1, remaining<=eff(t_hi).
    - HI -> LO: clk_o<=0, fall_o<=1, remaining<=eff(t_lo).
  - emu_dt > remaining: err_o<=1 (sticky until reset); otherwise handled exactly as the == case.
- t_lo/t_hi are sampled only at a phase load. Changing them mid-phase affects the next phase of that polarity only.
- Edge latency: clk_o, rise_o and fall_o update on the clk_i edge that consumes the final emu_dt. The edge is therefore visible at emulated time = phase start + duration.
- en_i=0 while in LO/HI:
  - The current phase completes normally.
  - At the next edge that would enter LO (a fall from HI, or the LO phase expiring), go to IDLE instead, with clk_o=0.
  - A pending rise (LO expiry) still goes to IDLE with no rise pulse.
- rise_o and fall_o are never both 1. Each is 0 in every cycle without an edge.
- emu_dt == 0: no state change; remaining is held.

Test Plan:
- Nominal clock:
  - Stimulus: reset, then en_i=1, t_lo=123, t_hi=234, emu_dt=dt_req each cycle.
  - Required: clk_o alternates every cycle; emu_time_o at successive rises/falls differs by exactly 123/234 for 10 periods; err_o=0.
- Foreign smaller timestep:
  - Stimulus: t_lo=100, t_hi=50, emu_dt=min(dt_req,30).
  - Required: rise after 4 grants (30,30,30,10); fall after 2 grants (30,20); dt_req sequence 100,70,40,10,50,20.
- Zero durations:
  - Stimulus: t_lo=0, t_hi=0.
  - Required: dt_req=1 always; clk_o toggles every cycle.
- Mid-phase update:
  - Stimulus: change t_hi from 234 to 500 while in LO.
  - Required: next high phase lasts 500.
  - Stimulus: change t_hi from 234 to 500 while in HI.
  - Required: current phase stays 234.
- Protocol violation:
  - Stimulus: force emu_dt=remaining+5.
  - Required: err_o=1 next cycle and stays 1; clk_o still toggles; reset clears err_o.
- Disable and reset:
  - Stimulus: drop en_i in HI.
  - Required: fall at phase end, then IDLE with dt_req=DT_MAX and clk_o=0.
  - Stimulus: assert rst_n_i=0 mid-LO.
  - Required: all outputs return to reset values on the next clk_i edge.
